// File: rtl/vai_tx_auditor_pkg.sv
// vai_tx_auditor_pkg: shared VAI constants, auditor state enum and the CCI-P request/response types.
package vai_tx_auditor_pkg;
    localparam int VAI_NUM_SUB_AFUS = 4;
    localparam int VAI_WINDOW_LOG2  = 26;
    localparam int VAI_OUTST_W      = 10;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HELD} t_vai_state;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [1:0]   t_ccip_clLen;
    typedef logic [1:0]   t_ccip_clNum;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {eVC_VA, eVC_VL0, eVC_VH0, eVC_VH1} t_ccip_vc;
    typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
    typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
                              eREQ_WRFENCE = 4'h4, eREQ_INTR = 4'h6} t_ccip_c1_req;
    typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
    typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6} t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;
endpackage

// File: rtl/vai_tx_auditor_outstanding_cnt.sv
// vai_outstanding_cnt: outstanding-line counter netting inc and dec each cycle, clamped to [0, all-ones].
module vai_outstanding_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] inc,
    input  logic [W-1:0] dec,
    output logic [W-1:0] cnt
);
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W-1:0] cnt_nxt;

    always_comb begin
        sum     = {1'b0, cnt} + {1'b0, inc};
        diff    = sum - {1'b0, dec};
        cnt_nxt = (sum < {1'b0, dec}) ? '0 : diff[W] ? '1 : diff[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_nxt;
    end
endmodule

// File: rtl/vai_tx_auditor.sv
// vai_tx_auditor: relocates and window-checks one sub-AFU's c0/c1 requests, and drains it on afu_reset.
module vai_tx_auditor
    import vai_tx_auditor_pkg::*;
#(
    parameter int WINDOW_LOG2 = VAI_WINDOW_LOG2,
    parameter int CNT_W       = 32
) (
    input  logic              pClk,
    input  logic              pck_cp2af_softReset,
    input  logic [63:0]       offset,
    input  logic              afu_reset,
    input  t_if_ccip_Tx       in_Tx,
    output t_if_ccip_Tx       out_Tx,
    input  t_if_ccip_Rx       in_Rx,
    output logic              quiesced,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  viol_cnt
);
    t_vai_state state, state_nxt;
    t_if_ccip_Tx s1, s1_d;
    logic [VAI_OUTST_W-1:0] c0_out, c1_out, c0_inc, c1_inc, c0_dec, c1_dec;
    logic running, idle, c1_fence, c0_ok, c1_ok;
    logic c0_fwd, c1_fwd, c0_viol, c1_viol, c0_drop, c1_drop;
    logic unused;

    function automatic logic in_window(input t_ccip_clAddr a, input t_ccip_clLen len);
        logic [WINDOW_LOG2:0] s;
        s = {1'b0, a[WINDOW_LOG2-1:0]} + (WINDOW_LOG2+1)'(len);
        return ((a >> WINDOW_LOG2) == '0) && !s[WINDOW_LOG2];
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(n);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign unused   = ^{offset[63:42], in_Tx.c2, in_Rx};
    assign running  = state == ST_RUN;
    assign idle     = (c0_out == '0) && (c1_out == '0);
    assign quiesced = state == ST_HELD;
    assign c1_fence = in_Tx.c1.hdr.req_type == eREQ_WRFENCE;
    assign c0_ok    = in_window(in_Tx.c0.hdr.address, in_Tx.c0.hdr.cl_len);
    assign c1_ok    = c1_fence || in_window(in_Tx.c1.hdr.address, in_Tx.c1.hdr.cl_len);
    assign c0_fwd   = in_Tx.c0.valid && running && c0_ok;
    assign c1_fwd   = in_Tx.c1.valid && running && c1_ok;
    assign c0_viol  = in_Tx.c0.valid && running && !c0_ok;
    assign c1_viol  = in_Tx.c1.valid && running && !c1_ok;
    assign c0_drop  = in_Tx.c0.valid && !running;
    assign c1_drop  = in_Tx.c1.valid && !running;

    always_comb begin
        state_nxt = (state == ST_RUN)   ? (afu_reset ? ST_DRAIN : ST_RUN) :
                    (state == ST_DRAIN) ? (idle ? (afu_reset ? ST_HELD : ST_RUN) : ST_DRAIN) :
                                          (afu_reset ? ST_HELD : ST_RUN);
    end

    always_comb begin
        s1_d                = '0;
        s1_d.c0             = in_Tx.c0;
        s1_d.c0.hdr.address = in_Tx.c0.hdr.address + offset[41:0];
        s1_d.c0.valid       = c0_fwd;
        s1_d.c1             = in_Tx.c1;
        s1_d.c1.hdr.address = c1_fence ? in_Tx.c1.hdr.address : in_Tx.c1.hdr.address + offset[41:0];
        s1_d.c1.valid       = c1_fwd;
    end

    // Lines are counted outstanding as soon as they enter the pipeline, so a drain waits for them too.
    always_comb begin
        c0_inc = c0_fwd ? VAI_OUTST_W'(in_Tx.c0.hdr.cl_len) + 1'b1 : '0;
        c1_inc = !c1_fwd ? '0 : c1_fence ? VAI_OUTST_W'(1) : VAI_OUTST_W'(in_Tx.c1.hdr.cl_len) + 1'b1;
        c0_dec = (in_Rx.c0.rspValid && in_Rx.c0.hdr.resp_type == eRSP_RDLINE) ? VAI_OUTST_W'(1) : '0;
        c1_dec = !in_Rx.c1.rspValid ? '0 :
                 in_Rx.c1.hdr.format ? VAI_OUTST_W'(in_Rx.c1.hdr.cl_num) + 1'b1 : VAI_OUTST_W'(1);
    end

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            state    <= ST_RUN;
            s1       <= '0;
            out_Tx   <= '0;
            drop_cnt <= '0;
            viol_cnt <= '0;
        end else begin
            state    <= state_nxt;
            s1       <= s1_d;
            out_Tx   <= s1;
            drop_cnt <= sat_add(drop_cnt, 2'(c0_drop) + 2'(c1_drop));
            viol_cnt <= sat_add(viol_cnt, 2'(c0_viol) + 2'(c1_viol));
        end
    end

    vai_outstanding_cnt #(.W(VAI_OUTST_W)) u_c0_cnt (
        .clk(pClk), .reset(pck_cp2af_softReset), .inc(c0_inc), .dec(c0_dec), .cnt(c0_out)
    );

    vai_outstanding_cnt #(.W(VAI_OUTST_W)) u_c1_cnt (
        .clk(pClk), .reset(pck_cp2af_softReset), .inc(c1_inc), .dec(c1_dec), .cnt(c1_out)
    );
endmodule
